// File: rtl/snd_pkg.sv
// rtl/snd_pkg.sv - shared types and defaults for the command sequencer
// Holds the sequencer state enum and the default response terminator byte.
package snd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        XMIT,
        WAIT_TX,
        WAIT_RESP
    } state_e;

    localparam logic [7:0] TERM_DEFAULT = 8'h0A;

endpackage

// File: rtl/resp_timer.sv
// rtl/resp_timer.sv - response inactivity timer
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the count (priority over en)
//   en        : count one cycle
//   expired   : count has reached TIMEOUT-1 while enabled
module resp_timer #(
    parameter int unsigned TIMEOUT = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [23:0] LAST = 24'(TIMEOUT - 1);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/snd_cmd_seq.sv
// rtl/snd_cmd_seq.sv - sends a ROM-resident command over UART and awaits a terminated response
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   send/cmd_start/cmd_len : command request (ignored unless idle and len != 0)
//   rom_addr/rom_dout    : synchronous ROM read port (data one cycle after address)
//   trmt/tx_data/tx_done : UART transmit strobe, byte, and byte-done flag
//   rx_rdy/rx_data/clr_rx_rdy : UART receive flag, byte, and acknowledge
//   busy, resp_rcvd, cmd_err, retry_cnt : status
module snd_cmd_seq
    import snd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned LEN_W     = 4,
    parameter logic [7:0]  TERM      = TERM_DEFAULT,
    parameter int unsigned TIMEOUT   = 2_500_000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_dout,
    output logic              trmt,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic              busy,
    output logic              resp_rcvd,
    output logic              cmd_err,
    output logic [2:0]        retry_cnt
);

    localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic [2:0]        retry_q, retry_d;

    logic expired;
    logic term_seen;
    logic timed_out;
    logic retry_ok;

    // Any received byte restarts the inactivity window; outside WAIT_RESP
    // the timer is held at zero so it starts fresh on entry.
    resp_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state_q != WAIT_RESP) || rx_rdy),
        .en     (state_q == WAIT_RESP),
        .expired(expired)
    );

    // A terminator in the expiry cycle wins over the timeout.
    assign term_seen = (state_q == WAIT_RESP) && rx_rdy && (rx_data == TERM);
    assign timed_out = (state_q == WAIT_RESP) && expired && !rx_rdy;
    assign retry_ok  = (retry_q < MAX_RETRY_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            left_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        len_d   = len_q;
        addr_d  = addr_q;
        left_d  = left_q;
        retry_d = retry_q;
        case (state_q)
            IDLE: begin
                if (send && (cmd_len != '0)) begin
                    start_d = cmd_start;
                    len_d   = cmd_len;
                    addr_d  = cmd_start;
                    left_d  = cmd_len;
                    retry_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = XMIT;
            XMIT: begin
                addr_d  = addr_q + 1'b1;
                left_d  = left_q - 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = (left_q != '0) ? XMIT : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (term_seen) begin
                    state_d = IDLE;
                end else if (timed_out) begin
                    if (retry_ok) begin
                        retry_d = retry_q + 3'd1;
                        addr_d  = start_q;
                        left_d  = len_q;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is high, even in the first reset
    // cycle before the registers have been cleared.
    always_comb begin
        rom_addr   = addr_q;
        trmt       = (state_q == XMIT);
        tx_data    = (state_q == XMIT) ? rom_dout : 8'h00;
        busy       = (state_q != IDLE);
        resp_rcvd  = term_seen;
        cmd_err    = timed_out && !retry_ok;
        retry_cnt  = retry_q;
        clr_rx_rdy = rx_rdy;
        if (rst) begin
            rom_addr  = '0;
            trmt      = 1'b0;
            tx_data   = 8'h00;
            busy      = 1'b0;
            resp_rcvd = 1'b0;
            cmd_err   = 1'b0;
            retry_cnt = 3'd0;
        end
    end

endmodule

// File: tb/tb_snd_cmd_seq.sv
// tb/tb_snd_cmd_seq.sv - scoreboard bench for snd_cmd_seq
module tb_snd_cmd_seq;

    localparam int AW = 5;
    localparam int LW = 4;
    localparam int TO = 50;
    localparam int MR = 2;
    localparam logic [7:0] TRM = 8'h0A;

    logic          clk = 1'b0;
    logic          rst, send, tx_done, rx_rdy;
    logic [AW-1:0] cmd_start, rom_addr;
    logic [LW-1:0] cmd_len;
    logic [7:0]    rom_dout, tx_data, rx_data;
    logic          trmt, clr_rx_rdy, busy, resp_rcvd, cmd_err;
    logic [2:0]    retry_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] rom [32];

    typedef struct {
        int addr;
        int data;
        int retry;
    } byte_t;

    byte_t exp_q[$];
    int    ev_q[$];   // 2 = resp_rcvd, 1 = cmd_err

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    snd_cmd_seq #(
        .ADDR_W(AW), .LEN_W(LW), .TERM(TRM), .TIMEOUT(TO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .send(send), .cmd_start(cmd_start), .cmd_len(cmd_len),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .busy(busy), .resp_rcvd(resp_rcvd), .cmd_err(cmd_err), .retry_cnt(retry_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        byte_t e;
        int    ev;
        if (!rst) begin
            if (trmt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_trmt", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_addr", 32'(rom_addr), e.addr);
                    chk("tx_data", 32'(tx_data), e.data);
                    chk("retry_at_byte", 32'(retry_cnt), e.retry);
                end
            end
            if (resp_rcvd || cmd_err) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, resp_rcvd, cmd_err}, 0);
                end else begin
                    ev = ev_q.pop_front();
                    chk("event", {30'd0, resp_rcvd, cmd_err}, ev);
                end
            end
            if (rx_rdy || clr_rx_rdy) chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(rx_rdy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        send    = 1'b0;
        tx_done = 1'b0;
        rx_rdy  = 1'b0;
    endtask

    task automatic wait_trmt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!trmt && n < 200);
        if (!trmt) chk("trmt_timeout", 0, 1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_trmt"}, 32'(trmt), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_resp"}, 32'(resp_rcvd), 0);
        chk({tag, "_err"}, 32'(cmd_err), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
    endtask

    // Entered in an XMIT cycle; leaves in the cycle the last tx_done is driven.
    task automatic xfer_bytes(input int len, input int dly, input bit spur);
        int n, d;
        for (int i = 0; i < len; i++) begin
            d = (dly < 0) ? int'($urandom_range(0, 8)) : dly;
            tick();
            if (spur && d >= 1) begin
                rx_rdy    = 1'b1;
                rx_data   = TRM;
                send      = 1'b1;
                cmd_start = AW'($urandom);
                cmd_len   = LW'($urandom);
            end
            repeat (d) tick();
            tx_done = 1'b1;
            if (i < len - 1) begin
                wait_trmt(n);
                chk("trmt_after_done", n, 1);
            end
        end
    endtask

    task automatic run_cmd(input int start, input int len, input int reply, input int npre,
                           input int gap, input int dly, input bit spur);
        int att, n, g;
        att = (reply >= 0) ? reply + 1 : MR + 1;
        for (int a = 0; a < att; a++)
            for (int i = 0; i < len; i++)
                exp_q.push_back('{(start + i) % 32, int'(rom[(start + i) % 32]), a});
        ev_q.push_back((reply >= 0) ? 2 : 1);
        tick();
        send      = 1'b1;
        cmd_start = AW'(start);
        cmd_len   = LW'(len);
        wait_trmt(n);
        chk("first_trmt_lat", n, 2);
        for (int a = 0; a < att; a++) begin
            xfer_bytes(len, dly, spur);
            if (a == reply) begin
                for (int k = 0; k <= npre; k++) begin
                    g = (gap > 0) ? gap : int'($urandom_range(1, 45));
                    repeat (g) tick();
                    rx_rdy  = 1'b1;
                    rx_data = (k == npre) ? TRM : 8'(8'h41 + k);
                end
                tick();
                chk("busy_after_resp", 32'(busy), 0);
            end else if (a < MR) begin
                wait_trmt(n);
                chk("retry_lat", n, TO + 2);
            end else begin
                n = 0;
                do begin
                    tick();
                    n++;
                end while (!cmd_err && n < 200);
                chk("cmd_err_lat", n, TO);
                tick();
                chk("busy_after_err", 32'(busy), 0);
            end
        end
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; send = 1'b0; tx_done = 1'b0; rx_rdy = 1'b0;
        rx_data = 8'h00; cmd_start = '0; cmd_len = '0;
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        rom[3] = 8'hA1; rom[4] = 8'hA2; rom[5] = 8'hA3; rom[6] = 8'hA4;

        repeat (3) tick();
        check_quiet("rst_held");
        rst = 1'b0;
        #1;
        check_quiet("rst_release");

        run_cmd(3, 4, 0, 0, 0, 9, 1'b0);
        run_cmd(30, 4, 0, 0, 0, -1, 1'b0);
        run_cmd(5, 3, -1, 0, 0, -1, 1'b0);
        chk("retry_final", 32'(retry_cnt), 2);
        tick();
        send = 1'b1; cmd_start = 5'd9; cmd_len = '0;
        repeat (4) tick();
        chk("len0_busy", 32'(busy), 0);
        chk("retry_held", 32'(retry_cnt), 2);
        run_cmd(10, 2, 0, 2, 40, -1, 1'b0);
        chk("retry_cleared", 32'(retry_cnt), 0);
        run_cmd(20, 5, 1, 1, 0, -1, 1'b1);
        chk("retry_one", 32'(retry_cnt), 1);

        // reset in the XMIT cycle of byte 2, after a send issued while busy
        tick();
        send = 1'b1; cmd_start = 5'd12; cmd_len = 4'd4;
        exp_q.push_back('{12, int'(rom[12]), 0});
        wait_trmt(n);
        chk("first_trmt_lat", n, 2);
        tick();
        send = 1'b1; cmd_start = 5'd0; cmd_len = 4'd2;
        repeat (2) tick();
        tx_done = 1'b1;
        wait_trmt(n);
        chk("trmt_after_done", n, 1);
        rst = 1'b1;
        #1;
        check_quiet("rst_mid");
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check_quiet("rst_mid_release");
        repeat (10) tick();
        chk("idle_after_rst", 32'(busy), 0);
        chk("rst_exp_drained", exp_q.size(), 0);

        for (int t = 0; t < 12; t++) begin
            run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(1, 15)),
                    int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 2)), 0, -1,
                    1'($urandom));
        end

        repeat (5) tick();
        chk("bytes_drained", exp_q.size(), 0);
        chk("events_drained", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
